muldiv_seq: RTL
===============

# muldiv_seq

Iterative sequencer for the RV32M multiply/divide instructions. It sits beside the main ALU in the execute stage. The decoder routes funct7=0000001 R-type instructions here instead of to the ALU. Each operation runs for a fixed number of cycles, and `busy` holds the pipeline stalled until the result is ready. Multiplication uses radix-2 shift-add; division uses restoring subtract; both work on magnitudes with sign fix-up at the end.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1: the single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request an operation. Sampled only in IDLE.
- `flush`  in  1: abort any in-flight operation (branch mispredict or trap).
- `funct3`  in  3: M-extension op. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  32: rs1 value.
- `op_b`  in  32: rs2 value.
- `busy`  out  1: high when state ≠ IDLE.
- `done`  out  1: one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32: registered result, held until the next `done`.

## Operation
- States and transitions:
  - IDLE → CALC on `start & ~flush`. On this edge, latch funct3, the magnitudes of op_a and op_b, the sign flags, and clear `cnt`.
  - CALC stays for 32 cycles. `cnt` runs 0..31; at `cnt==31`, go to DONE.
  - DONE → IDLE unconditionally.
- Signedness of each operand:
  - op_a is signed for MULH, MULHSU, DIV and REM.
  - op_b is signed for MULH, DIV and REM.
  - An operand is negated only if it is signed and its bit 31 is set.
- Multiply: 64-bit accumulator. Each iteration adds the multiplicand if the multiplier LSB is 1, then shifts. The product is negated if sign_a^sign_b. MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide: 32-bit remainder and quotient registers. Each iteration shifts the remainder in and subtracts the divisor if the result is ≥0.
  - Quotient is negated if sign_a^sign_b (DIV).
  - Remainder is negated if sign_a (REM).
- Special cases (RISC-V defined):
  - Divide by zero: quotient 0xFFFFFFFF, remainder = op_a.
  - DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `result` is written on the CALC→DONE edge.
- `start` while busy is ignored. The pipeline must hold `start` and its operands stable while `busy` is high.
- `flush` in CALC or DONE: go to IDLE on the next edge. No `done` pulse is produced for the aborted operation (`done` is forced low in the flush cycle), and `result` is not updated.
- `flush` together with `start` in IDLE: flush wins and nothing is accepted.
- Reset (any time, including mid-operation): state IDLE, `busy` 0, `done` 0, `result` 0, `cnt` 0, all internal registers 0.

## Timing
- Start sampled in cycle 0. CALC occupies cycles 1–32. DONE is cycle 33, with `done`=1, `busy`=1 and `result` valid.
- In cycle 34, `busy`=0, and a new `start` can be sampled. Back-to-back throughput is one operation per 34 cycles.
- `busy` is registered and never combinational from `start`. The stall logic ORs `start` from decode itself.
- Latency is independent of operand values unless the fast-path feature is enabled.

## Configuration
- `MULDIV_FASTPATH_EN` defined:
  - Applies to divide by zero, signed overflow, and multiply with op_a or op_b equal to 0.
  - These cases go IDLE→DONE directly: `done` in cycle 1, `busy` high only in cycle 1.
  - `result` takes the special value, or 0 for the zero-multiply cases.
- Undefined: every operation takes the full 33-cycle path. The special values still come out correctly through the final fix-up logic.

## Structure
- `defines.v` holds:
  - the funct3 codes `F3_MUL`, `F3_MULH`, `F3_MULHSU`, `F3_MULHU`, `F3_DIV`, `F3_DIVU`, `F3_REM`, `F3_REMU`;
  - `MD_ITER`=32;
  - the state encodings `MD_IDLE`, `MD_CALC`, `MD_DONE`.
- Sub-module `muldiv_step` is combinational and computes one iteration: the next {accumulator, multiplier} for multiply, or the next {remainder, quotient} for divide. `muldiv_seq` owns the FSM, counter, registers and sign fix-up.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), start in cycle 0 → `done` in cycle 33 only, `result`=0xFFFFFFEB, `busy` high in cycles 1–33.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC. REMU → 1.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000 and REM → 0. `done` in cycle 33, or cycle 1 with `MULDIV_FASTPATH_EN`.
- `flush` in cycle 10 → no `done`, `busy`=0 in cycle 11, `result` unchanged. `start` in cycle 11 is accepted. `start` with `flush` in IDLE is ignored.
- Deassert `rst_n` in cycle 20 of a DIV → `busy`, `done` and `result` go to 0 immediately. After release, a new MUL 3×4 yields 12 after the full 33-cycle latency.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_pkg
// Shared definitions for the RV32M multiply/divide sequencer:
//   - funct3 operation codes (F3_*)
//   - iteration count (MD_ITER)
//   - FSM state encodings (MD_IDLE, MD_CALC, MD_DONE)
//   - helpers that decode operand signedness and op class from funct3
// -----------------------------------------------------------------------------
package muldiv_seq_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Divide class is the upper half of the funct3 space.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // op_a is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // op_b is treated as signed for MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single iteration of the sequencer datapath.
//   Multiply (div_mode=0): {hi, lo} is {accumulator, multiplier}. The
//     multiplicand is added to hi when lo[0] is set, then the 65-bit
//     {carry, sum, lo} is shifted right by one.
//   Divide   (div_mode=1): {hi, lo} is {remainder, quotient}. The next
//     dividend bit (lo MSB) is shifted into the remainder and the divisor is
//     subtracted if the difference is non-negative (restoring division).
// Ports:
//   div_mode in  1 : select divide iteration
//   hi       in  W : accumulator / remainder
//   lo       in  W : multiplier / quotient (dividend bits shift out the top)
//   mcand    in  W : multiplicand / divisor magnitude
//   hi_next  out W : next accumulator / remainder
//   lo_next  out W : next multiplier / quotient
// -----------------------------------------------------------------------------
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         div_mode,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] mcand,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] lo_next
);

  logic [W:0] sum_s;
  logic [W:0] shl_s;
  logic [W:0] diff_s;

  // One shift-add or restoring-subtract iteration.
  always_comb begin
    sum_s   = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {W{1'b0}})};
    shl_s   = {hi, lo[W-1]};
    diff_s  = shl_s - {1'b0, mcand};
    hi_next = {W{1'b0}};
    lo_next = {W{1'b0}};
    if (div_mode) begin
      // Top bit of the difference is the borrow: clear means remainder >= divisor.
      if (!diff_s[W]) begin
        hi_next = diff_s[W-1:0];
        lo_next = {lo[W-2:0], 1'b1};
      end else begin
        hi_next = shl_s[W-1:0];
        lo_next = {lo[W-2:0], 1'b0};
      end
    end else begin
      hi_next = sum_s[W:1];
      lo_next = {sum_s[0], lo[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Iterative RV32M multiply/divide sequencer. Operands are reduced to
// magnitudes on acceptance, iterated MD_ITER times through muldiv_step, and
// sign-corrected on the final edge into the registered result.
// Optional feature macro: MULDIV_FASTPATH_EN -- divide by zero, signed
// divide overflow and multiply by zero skip CALC and finish in one cycle.
// Ports:
//   clk     in  1    : clock, rising edge
//   rst_n   in  1    : asynchronous active-low reset
//   start   in  1    : operation request, sampled only in IDLE
//   flush   in  1    : abort in-flight operation; blocks start in IDLE
//   funct3  in  3    : M-extension operation code
//   op_a    in  XLEN : rs1 value
//   op_b    in  XLEN : rs2 value
//   busy    out 1    : state is not IDLE (registered)
//   done    out 1    : one-cycle pulse with result valid, suppressed by flush
//   result  out XLEN : registered result, held until the next done
// -----------------------------------------------------------------------------
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [4:0] CNT_LAST = 5'(MD_ITER - 1);

  md_state_e       state_r;
  logic [4:0]      cnt_r;
  logic [2:0]      f3_r;
  logic            sign_a_r;
  logic            sign_b_r;
  logic [XLEN-1:0] hi_r;
  logic [XLEN-1:0] lo_r;
  logic [XLEN-1:0] mcand_r;
  logic            busy_r;
  logic            done_r;
  logic [XLEN-1:0] result_r;

  logic            sign_a_s;
  logic            sign_b_s;
  logic [XLEN-1:0] mag_a_s;
  logic [XLEN-1:0] mag_b_s;
  logic            fast_s;
  logic [XLEN-1:0] fast_res_s;
  logic [XLEN-1:0] hi_nx_s;
  logic [XLEN-1:0] lo_nx_s;
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0] quo_fix_s;
  logic [XLEN-1:0] rem_fix_s;
  logic [XLEN-1:0] result_nx_s;

  // Operand sign flags and magnitudes taken at acceptance.
  always_comb begin
    sign_a_s = a_is_signed(funct3) & op_a[XLEN-1];
    sign_b_s = b_is_signed(funct3) & op_b[XLEN-1];
    if (sign_a_s) begin
      mag_a_s = ~op_a + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      mag_a_s = op_a;
    end
    if (sign_b_s) begin
      mag_b_s = ~op_b + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      mag_b_s = op_b;
    end
  end

`ifdef MULDIV_FASTPATH_EN
  // Detect operations whose result is known without iterating.
  always_comb begin
    fast_s     = 1'b0;
    fast_res_s = {XLEN{1'b0}};
    if (is_div(funct3)) begin
      if (op_b == {XLEN{1'b0}}) begin
        fast_s     = 1'b1;
        fast_res_s = funct3[1] ? op_a : {XLEN{1'b1}};
      end else if (!funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (op_b == {XLEN{1'b1}})) begin
        fast_s     = 1'b1;
        fast_res_s = funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
        fast_s     = 1'b0;
        fast_res_s = {XLEN{1'b0}};
      end
    end else begin
      if ((op_a == {XLEN{1'b0}}) || (op_b == {XLEN{1'b0}})) begin
        fast_s     = 1'b1;
        fast_res_s = {XLEN{1'b0}};
      end else begin
        fast_s     = 1'b0;
        fast_res_s = {XLEN{1'b0}};
      end
    end
  end
`else
  // Every operation takes the full iterative path.
  always_comb begin
    fast_s     = 1'b0;
    fast_res_s = {XLEN{1'b0}};
  end
`endif

  muldiv_step #(
    .W (XLEN)
  ) u_step (
    .div_mode (is_div(f3_r)),
    .hi       (hi_r),
    .lo       (lo_r),
    .mcand    (mcand_r),
    .hi_next  (hi_nx_s),
    .lo_next  (lo_nx_s)
  );

  // Sign fix-up applied to the output of the final iteration.
  always_comb begin
    prod_s = {hi_nx_s, lo_nx_s};
    if (sign_a_r ^ sign_b_r) begin
      prod_fix_s = ~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1};
    end else begin
      prod_fix_s = prod_s;
    end
    // A zero divisor leaves an all-ones quotient that must not be negated.
    if (mcand_r == {XLEN{1'b0}}) begin
      quo_fix_s = {XLEN{1'b1}};
    end else if (sign_a_r ^ sign_b_r) begin
      quo_fix_s = ~lo_nx_s + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      quo_fix_s = lo_nx_s;
    end
    if (sign_a_r) begin
      rem_fix_s = ~hi_nx_s + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      rem_fix_s = hi_nx_s;
    end
    case (f3_r)
      F3_MUL:                         result_nx_s = prod_fix_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   result_nx_s = prod_fix_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                result_nx_s = quo_fix_s;
      F3_REM, F3_REMU:                result_nx_s = rem_fix_s;
      default:                        result_nx_s = {XLEN{1'b0}};
    endcase
  end

  // Sequencer FSM with iteration counter, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= MD_IDLE;
      cnt_r    <= 5'd0;
      f3_r     <= 3'd0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      mcand_r  <= {XLEN{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start && !flush) begin
            if (fast_s) begin
              state_r  <= MD_DONE;
              busy_r   <= 1'b1;
              done_r   <= 1'b1;
              result_r <= fast_res_s;
            end else begin
              state_r  <= MD_CALC;
              busy_r   <= 1'b1;
              done_r   <= 1'b0;
              cnt_r    <= 5'd0;
              f3_r     <= funct3;
              sign_a_r <= sign_a_s;
              sign_b_r <= sign_b_s;
              hi_r     <= {XLEN{1'b0}};
              // Divide iterates over the dividend; multiply over the multiplier.
              lo_r     <= is_div(funct3) ? mag_a_s : mag_b_s;
              mcand_r  <= is_div(funct3) ? mag_b_s : mag_a_s;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        MD_CALC: begin
          if (flush) begin
            state_r <= MD_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else begin
            hi_r  <= hi_nx_s;
            lo_r  <= lo_nx_s;
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == CNT_LAST) begin
              state_r  <= MD_DONE;
              done_r   <= 1'b1;
              result_r <= result_nx_s;
            end else begin
              done_r <= 1'b0;
            end
          end
        end
        MD_DONE: begin
          state_r <= MD_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= MD_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  // A flush arriving in the DONE cycle suppresses the pulse.
  assign done   = done_r & ~flush;
  assign result = result_r;

endmodule
